// File: rtl/cpu_run_pkg.sv
// Shared encodings for the rv32is run/step controller: status codes,
// mode select values and default self-check magic numbers.
package cpu_run_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PAUSE   = 3'd2,
        ST_PASS    = 3'd3,
        ST_FAIL    = 3'd4,
        ST_TIMEOUT = 3'd5,
        ST_RESET   = 3'd6,
        ST_STEP    = 3'd7
    } run_state_t;

    localparam logic MODE_FREE = 1'b0;
    localparam logic MODE_STEP = 1'b1;

    localparam int          DEF_MON_REG    = 10;
    localparam logic [31:0] DEF_PASS_MAGIC = 32'h00c0ffee;
    localparam logic [31:0] DEF_FAIL_MAGIC = 32'hdeaddead;

    // States where the core is parked and halt_pc captures where it stopped
    function automatic logic is_halt_state(input run_state_t s);
        return (s == ST_PAUSE) || (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
    endfunction

    // States where the controller is actively clocking the core
    function automatic logic is_busy_state(input run_state_t s);
        return (s == ST_RESET) || (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/run_step_counter.sv
// Loadable down-counter used for both the reset hold count and the step count.
// expire is high while the count is at one or zero, i.e. the decrement on the
// coming edge brings it to zero.
module run_step_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expire
);

    logic [W-1:0] count;

    // Load has priority over decrement; the count never wraps below zero
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign expire = (count <= W'(1));

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step controller and pass/fail monitor for the rv32is single-cycle core.
// Sequences core reset, gates the core clock enable for free-run and stepping,
// and halts on breakpoint, stop, timeout or a magic write to the monitored register.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int                DATA_W       = 32,
    parameter int                CYCLE_W      = 16,
    parameter int                MAX_CYCLES   = 10000,
    parameter int                RESET_CYCLES = 1,
    parameter int                MON_REG      = DEF_MON_REG,
    parameter logic [DATA_W-1:0] PASS_MAGIC   = DATA_W'(DEF_PASS_MAGIC),
    parameter logic [DATA_W-1:0] FAIL_MAGIC   = DATA_W'(DEF_FAIL_MAGIC)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               mode,
    input  logic               step_req,
    input  logic [CYCLE_W-1:0] step_n,
    input  logic               stop,
    input  logic               resume,
    input  logic               bp_en,
    input  logic [DATA_W-1:0]  bp_addr,
    input  logic [DATA_W-1:0]  pc_in,
    input  logic               wb_we,
    input  logic [4:0]         wb_rd,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               cpu_reset,
    output logic               cpu_clk_en,
    output logic               busy,
    output logic [2:0]         status,
    output logic [CYCLE_W-1:0] cycle_count,
    output logic [DATA_W-1:0]  halt_pc
);

    run_state_t         state;
    run_state_t         next_state;

    logic               rcnt_load;
    logic               rcnt_dec;
    logic               rcnt_expire;
    logic               scnt_load;
    logic               scnt_dec;
    logic               scnt_expire;
    logic               clear_cycles;
    logic               arm_bp_mask;
    logic               bp_mask;

    logic               mon_write;
    logic               pass_write;
    logic               fail_write;
    logic               bp_hit;
    logic               timeout_next;
    logic               core_exec;
    logic [CYCLE_W-1:0] step_load;

    // x0 can never hold a value, so a write to it is never a magic hit
    assign mon_write    = wb_we && (wb_rd == 5'(MON_REG)) && (wb_rd != 5'd0);
    assign pass_write   = mon_write && (wb_data == PASS_MAGIC);
    assign fail_write   = mon_write && (wb_data == FAIL_MAGIC);
    assign bp_hit       = bp_en && (pc_in == bp_addr) && !bp_mask;
    assign timeout_next = (cycle_count >= CYCLE_W'(MAX_CYCLES - 1));
    assign step_load    = (step_n == '0) ? CYCLE_W'(1) : step_n;
    assign core_exec    = cpu_clk_en && !cpu_reset;

    assign busy   = is_busy_state(state);
    assign status = state;

    run_step_counter #(.W(CYCLE_W)) u_rcnt (
        .clock    (clock),
        .reset    (reset),
        .load     (rcnt_load),
        .load_val (CYCLE_W'(RESET_CYCLES)),
        .dec      (rcnt_dec),
        .expire   (rcnt_expire)
    );

    run_step_counter #(.W(CYCLE_W)) u_scnt (
        .clock    (clock),
        .reset    (reset),
        .load     (scnt_load),
        .load_val (step_load),
        .dec      (scnt_dec),
        .expire   (scnt_expire)
    );

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and core controls; an executed cycle's magic result beats timeout, which beats stop
    always_comb begin
        next_state   = state;
        cpu_reset    = 1'b0;
        cpu_clk_en   = 1'b0;
        rcnt_load    = 1'b0;
        rcnt_dec     = 1'b0;
        scnt_load    = 1'b0;
        scnt_dec     = 1'b0;
        clear_cycles = 1'b0;
        arm_bp_mask  = 1'b0;
        case (state)
            ST_IDLE: begin
                cpu_reset = 1'b1;
                if (start) begin
                    next_state   = ST_RESET;
                    rcnt_load    = 1'b1;
                    clear_cycles = 1'b1;
                end
            end
            ST_RESET: begin
                cpu_reset  = 1'b1;
                cpu_clk_en = 1'b1;
                rcnt_dec   = 1'b1;
                if (rcnt_expire) begin
                    next_state = (mode == MODE_STEP) ? ST_PAUSE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (bp_hit) begin
                    next_state = ST_PAUSE;
                end else begin
                    cpu_clk_en = 1'b1;
                    if (pass_write) begin
                        next_state = ST_PASS;
                    end else if (fail_write) begin
                        next_state = ST_FAIL;
                    end else if (timeout_next) begin
                        next_state = ST_TIMEOUT;
                    end else if (stop) begin
                        next_state = ST_PAUSE;
                    end
                end
            end
            ST_PAUSE: begin
                if (step_req) begin
                    next_state = ST_STEP;
                    scnt_load  = 1'b1;
                end else if (resume) begin
                    next_state  = ST_RUN;
                    arm_bp_mask = 1'b1;
                end
            end
            ST_STEP: begin
                cpu_clk_en = 1'b1;
                scnt_dec   = 1'b1;
                if (pass_write) begin
                    next_state = ST_PASS;
                end else if (fail_write) begin
                    next_state = ST_FAIL;
                end else if (timeout_next) begin
                    next_state = ST_TIMEOUT;
                end else if (stop || scnt_expire) begin
                    next_state = ST_PAUSE;
                end
            end
            ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                if (start) begin
                    next_state   = ST_RESET;
                    rcnt_load    = 1'b1;
                    clear_cycles = 1'b1;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Count executed core cycles, saturating so a long run never wraps
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_count <= '0;
        end else if (clear_cycles) begin
            cycle_count <= '0;
        end else if (core_exec && (cycle_count != '1)) begin
            cycle_count <= cycle_count + CYCLE_W'(1);
        end
    end

    // Mask the breakpoint for the first cycle after resume so the PC can leave bp_addr
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bp_mask <= 1'b0;
        end else begin
            bp_mask <= arm_bp_mask;
        end
    end

    // Capture the PC whenever the core is parked in pause or a terminal state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            halt_pc <= '0;
        end else if ((next_state != state) && is_halt_state(next_state)) begin
            halt_pc <= pc_in;
        end
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Synthesizable run/step controller and self-check monitor for the rv32is single-cycle core. It sequences CPU reset and gates the core clock enable for free-run, N-step and single-step operation. It halts on breakpoint, stop or timeout, and snoops register write-back for the pass/fail magic number in a monitored register. It sits between the board/test harness and the core, and replaces bench-only cycle counting and magic-number checks with hardware that is also usable on the FPGA.

Parameters:
DATA_W, 32, width of write-back data and PC
CYCLE_W, 16, width of cycle and step counters
MAX_CYCLES, 10000, timeout limit in enabled cycles
RESET_CYCLES, 1, number of cycles cpu_reset is held high
MON_REG, 10, register index watched for magic values (a0)
PASS_MAGIC, 32'h00c0ffee, value that signals pass
FAIL_MAGIC, 32'hdeaddead, value that signals fail

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  pulse; begin a run (from IDLE or any terminal state)
mode  in  1  0 = free run, 1 = start paused (step mode)
step_req  in  1  pulse; in PAUSE, run step_n enabled cycles
step_n  in  CYCLE_W  step count; value 0 is treated as 1
stop  in  1  pulse; RUN -> PAUSE
resume  in  1  pulse; PAUSE -> RUN
bp_en  in  1  breakpoint enable
bp_addr  in  DATA_W  breakpoint PC
pc_in  in  DATA_W  core current PC (dbgdata)
wb_we  in  1  core regfile write enable
wb_rd  in  5  core write register index
wb_data  in  DATA_W  core write data
cpu_reset  out  1  active-high reset to core
cpu_clk_en  out  1  core clock enable
busy  out  1  high in RESET, RUN or STEP
status  out  3  IDLE=0, RUN=1, PAUSE=2, PASS=3, FAIL=4, TIMEOUT=5, RESET=6, STEP=7
cycle_count  out  CYCLE_W  enabled cycles since the core left reset
halt_pc  out  DATA_W  pc_in latched on entry to PAUSE or a terminal state

Behaviour:
- Reset (async, low): state IDLE, cpu_reset=1, cpu_clk_en=0, busy=0, cycle_count=0, halt_pc=0, step counter=0.
- IDLE: cpu_reset=1. On start -> RESET with rcnt=RESET_CYCLES; cycle_count cleared.
- RESET: cpu_reset=1 and cpu_clk_en=1 for RESET_CYCLES edges. Then cpu_reset=0 and the next state is RUN if mode=0, or PAUSE if mode=1.
- RUN: cpu_clk_en=1. Each edge with cpu_clk_en=1 and cpu_reset=0 increments cycle_count (saturating at all-ones).
- Write-back check: when cpu_clk_en, wb_we and wb_rd==MON_REG are all set in the same cycle, and wb_rd!=0:
  - wb_data==PASS_MAGIC -> PASS
  - wb_data==FAIL_MAGIC -> FAIL
  - PASS takes priority if the two magic values are equal.
- Timeout: cycle_count reaching MAX_CYCLES on an enabled edge with no magic hit -> TIMEOUT. If magic and timeout occur on the same edge, the magic result wins.
- Breakpoint: bp_en && pc_in==bp_addr while in RUN -> PAUSE before that instruction executes. cpu_clk_en is combinationally 0 that cycle, so the instruction at bp_addr is not executed.
- stop in RUN -> PAUSE on the next edge. The current cycle still executes.
- PAUSE: cpu_clk_en=0.
  - step_req -> STEP, loading scnt=max(step_n,1).
  - resume -> RUN. The breakpoint is ignored for the first RUN cycle so the PC can leave bp_addr.
  - If step_req and resume arrive together, step_req wins.
- STEP: cpu_clk_en=1; scnt decrements per enabled edge; scnt reaching 0 -> PAUSE. Magic and timeout checks still apply; breakpoints are ignored. stop aborts to PAUSE.
- Terminal states (PASS/FAIL/TIMEOUT): cpu_clk_en=0, cpu_reset=0; state held so the core state stays inspectable. start -> RESET (full re-run). All other inputs are ignored.
- halt_pc updates on every entry to PAUSE/PASS/FAIL/TIMEOUT.
- start outside IDLE or terminal states is ignored.
- Latency:
  - start to first executed instruction: RESET_CYCLES+1 edges.
  - magic write to status update: same edge.

Decomposition:
- Package cpu_run_pkg holds:
  - the status/state encoding constants (3-bit)
  - mode constants
  - default PASS_MAGIC/FAIL_MAGIC/MON_REG values
- One sub-module, run_step_counter: loadable down-counter with zero detect, used for both rcnt and scnt.
- The FSM, cycle counter and compare logic live in the top module.

Test Plan:
- Free run with a core model that writes 0x00c0ffee to x10 at enabled cycle 14 -> status=PASS after that edge, cycle_count=14, cpu_clk_en=0, busy=0.
- Core writes 0xdeaddead to x10 at cycle 5, plus an earlier write of 0x00c0ffee to x11 at cycle 3 -> x11 write ignored; status=FAIL, cycle_count=5.
- MAX_CYCLES=20 with no magic -> status=TIMEOUT after cycle_count=20; also force the magic write on cycle 20 -> PASS wins.
- bp_en=1, bp_addr=0x44, PC sequence 0,4,...,0x44 -> PAUSE with halt_pc=0x44, cpu_clk_en=0 at that cycle; resume -> PC advances past 0x44 without re-halting.
- mode=1, step_n=3, step_req -> exactly 3 cpu_clk_en cycles, then PAUSE; step_n=0 -> exactly 1 cycle.
- Assert reset low mid-RUN -> immediate IDLE, cpu_reset=1, cycle_count=0. A subsequent start holds cpu_reset high for RESET_CYCLES and restarts from PC 0.
